// File: rtl/jzjpcc_pkg.sv
// Shared types for the jzjpcc fetch-control slice.
//   fetchCtrlState_t : fetch sequencer state (BOOT, RUN, HALTING, HALTED)
package jzjpcc_pkg;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    HALTING = 2'd2,
    HALTED  = 2'd3
  } fetchCtrlState_t;

endpackage

// File: rtl/jzjpcc_event_counter.sv
// Free-running event counter, wraps modulo 2^WIDTH.
//   clock     : in  posedge clock
//   reset     : in  asynchronous active-low reset, clears count
//   increment : in  count this cycle
//   count     : out current count
module jzjpcc_event_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             increment,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (increment) count_d = count_q + WIDTH'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/jzjpcc_fetch_control.sv
// Fetch-stage sequencer: sole driver of fetch's stall_fetch / flush_decode.
// Arbitrates boot flushing, load-use stalls, control-transfer redirects and
// debug halt/resume, and keeps fetch/stall performance counters.
//   clock           : in  posedge clock
//   reset           : in  asynchronous active-low reset
//   loadUseHazard   : in  decode needs a load result not yet available
//   pcCTWriteEnable : in  decode redirects PC this cycle
//   haltRequest     : in  debug level halt request
//   resumeRequest   : in  debug one-cycle resume pulse
//   stall_fetch     : out hold PC
//   flush_decode    : out load nop into decode
//   halted          : out fetch halted (registered)
//   fetchCount      : out RUN cycles where a real instruction entered decode
//   stallCount      : out RUN cycles stalled by loadUseHazard
module jzjpcc_fetch_control
  import jzjpcc_pkg::*;
#(
  parameter int unsigned BOOT_FLUSH_CYCLES = 2,
  parameter int unsigned COUNTER_WIDTH     = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     loadUseHazard,
  input  logic                     pcCTWriteEnable,
  input  logic                     haltRequest,
  input  logic                     resumeRequest,
  output logic                     stall_fetch,
  output logic                     flush_decode,
  output logic                     halted,
  output logic [COUNTER_WIDTH-1:0] fetchCount,
  output logic [COUNTER_WIDTH-1:0] stallCount
);

  localparam int unsigned BOOT_CNT_W =
    (BOOT_FLUSH_CYCLES > 1) ? $clog2(BOOT_FLUSH_CYCLES) : 1;
  localparam logic [BOOT_CNT_W-1:0] BOOT_LAST = BOOT_CNT_W'(BOOT_FLUSH_CYCLES - 1);

  fetchCtrlState_t       state_q, state_d;
  logic [BOOT_CNT_W-1:0] bootCnt_q, bootCnt_d;
  logic                  haltPending_q, haltPending_d;
  logic                  fetchInc;
  logic                  stallInc;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= BOOT;
      bootCnt_q     <= '0;
      haltPending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bootCnt_q     <= bootCnt_d;
      haltPending_q <= haltPending_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bootCnt_d     = bootCnt_q;
    haltPending_d = haltPending_q;
    stall_fetch   = 1'b1;
    flush_decode  = 1'b1;
    fetchInc      = 1'b0;
    stallInc      = 1'b0;

    unique case (state_q)
      BOOT: begin
        if (haltRequest) haltPending_d = 1'b1;
        if (bootCnt_q == BOOT_LAST) begin
          state_d   = RUN;
          bootCnt_d = '0;
        end else begin
          bootCnt_d = bootCnt_q + BOOT_CNT_W'(1);
        end
      end

      RUN: begin
        if (loadUseHazard) begin
          // Redirect is dropped here: its operands are stale and decode
          // re-asserts it once the load result arrives.
          stall_fetch  = 1'b1;
          flush_decode = 1'b0;
          stallInc     = 1'b1;
          if (haltRequest) haltPending_d = 1'b1;
        end else if (pcCTWriteEnable) begin
          stall_fetch  = 1'b0;
          flush_decode = 1'b1;
          if (haltRequest) haltPending_d = 1'b1;
        end else if (haltRequest || haltPending_q) begin
          state_d       = HALTING;
          haltPending_d = 1'b0;
        end else begin
          stall_fetch  = 1'b0;
          flush_decode = 1'b0;
          fetchInc     = 1'b1;
        end
      end

      HALTING: state_d = HALTED;

      HALTED: begin
        if (resumeRequest && !haltRequest) state_d = RUN;
      end

      default: begin
        state_d       = BOOT;
        bootCnt_d     = '0;
        haltPending_d = 1'b0;
      end
    endcase
  end

  assign halted = (state_q == HALTED);

  jzjpcc_event_counter #(.WIDTH(COUNTER_WIDTH)) u_fetch_counter (
    .clock     (clock),
    .reset     (reset),
    .increment (fetchInc),
    .count     (fetchCount)
  );

  jzjpcc_event_counter #(.WIDTH(COUNTER_WIDTH)) u_stall_counter (
    .clock     (clock),
    .reset     (reset),
    .increment (stallInc),
    .count     (stallCount)
  );

endmodule
